// File: rtl/dma_fifo_drain_if.sv
// FIFO read port and openMSP430 DMA write port seen by the FIFO drain engine.
// master: the drain engine. slave: the FIFO / DMA side.
interface dma_fifo_drain_if #(
  parameter int DATA   = 16,
  parameter int ADDR_W = 15
);
  logic              fifo_empty;
  logic [DATA-1:0]   fifo_out;
  logic              fifo_enable;
  logic              fifo_wr_rd;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA-1:0]   dma_din;
  logic              dma_en;
  logic [1:0]        dma_we;
  logic              dma_ready;
  logic              dma_resp;

  modport master (
    input  fifo_empty, fifo_out, dma_ready, dma_resp,
    output fifo_enable, fifo_wr_rd, dma_addr, dma_din, dma_en, dma_we
  );

  modport slave (
    output fifo_empty, fifo_out, dma_ready, dma_resp,
    input  fifo_enable, fifo_wr_rd, dma_addr, dma_din, dma_en, dma_we
  );
endinterface

// File: rtl/dma_fifo_drain.sv
// Read-side master of the DMA controller FIFO: pops one word at a time and
// writes it to data memory through the DMA port, with wait states, bounded
// bus-error retry, address wrap, abort and completion reporting.
module dma_fifo_drain #(
  parameter int DATA      = 16,
  parameter int ADDR_W    = 15,
  parameter int LEN_W     = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_left,
  dma_fifo_drain_if.master  bus
);

  // Retry counter must hold 0..MAX_RETRY.
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]    RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [LEN_W-1:0] ONE_WORD  = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WRITE = 3'd2,
    S_RESP  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA-1:0]   din_reg;
  logic [LEN_W-1:0]  left_reg;
  logic [RW-1:0]     retry_reg;
  logic              abort_pend_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              error_reg;

  logic idle_like;
  logic zero_len;
  logic last_word;
  logic retry_max;
  logic abort_seen;

  assign idle_like  = (state_reg == S_IDLE) || (state_reg == S_ERROR);
  assign zero_len   = (length == '0);
  assign last_word  = (left_reg == ONE_WORD);
  assign retry_max  = (retry_reg == RETRY_LIM);
  // An abort raised during WRITE is remembered; one raised in RESP counts too.
  assign abort_seen = abort_pend_reg | abort;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE, S_ERROR: begin
        if (start) state_next = zero_len ? S_IDLE : S_FETCH;
      end
      S_FETCH: begin
        if (abort)                state_next = S_IDLE;
        else if (!bus.fifo_empty) state_next = S_WRITE;
      end
      S_WRITE: begin
        // A request once issued is held until granted, abort or not.
        if (bus.dma_ready) state_next = S_RESP;
      end
      S_RESP: begin
        if (!bus.dma_resp)  state_next = (last_word || abort_seen) ? S_IDLE : S_FETCH;
        else if (!retry_max) state_next = S_WRITE;
        else                 state_next = S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes decoded from the current state; never from same-cycle fifo_out.
  always_comb begin
    bus.fifo_enable = 1'b0;
    bus.dma_en      = 1'b0;
    bus.dma_we      = 2'b00;
    if (state_reg == S_FETCH) bus.fifo_enable = !bus.fifo_empty && !abort;
    if (state_reg == S_WRITE) begin
      bus.dma_en = 1'b1;
      bus.dma_we = 2'b11;
    end
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_reg       <= '0;
      din_reg        <= '0;
      left_reg       <= '0;
      retry_reg      <= '0;
      abort_pend_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      busy_reg <= (state_next == S_FETCH) || (state_next == S_WRITE) ||
                  (state_next == S_RESP);
      unique case (state_reg)
        S_IDLE, S_ERROR: begin
          if (start) begin
            error_reg      <= 1'b0;
            abort_pend_reg <= 1'b0;
            if (zero_len) begin
              done_reg <= 1'b1;
              left_reg <= '0;
            end else begin
              addr_reg <= base_addr;
              left_reg <= length;
            end
          end
        end
        S_FETCH: begin
          if (abort) begin
            done_reg <= 1'b1;
          end else if (!bus.fifo_empty) begin
            din_reg   <= bus.fifo_out;
            retry_reg <= '0;
          end
        end
        S_WRITE: begin
          if (abort) abort_pend_reg <= 1'b1;
        end
        S_RESP: begin
          if (abort) abort_pend_reg <= 1'b1;
          if (!bus.dma_resp) begin
            addr_reg <= addr_reg + 1'b1;
            left_reg <= left_reg - 1'b1;
            if (last_word || abort_seen) done_reg <= 1'b1;
          end else if (!retry_max) begin
            retry_reg <= retry_reg + 1'b1;
          end else begin
            // Failed word stays counted in words_left; no done pulse.
            error_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_wr_rd = 1'b0;
  assign bus.dma_addr   = addr_reg;
  assign bus.dma_din    = din_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign error          = error_reg;
  assign words_left     = left_reg;

endmodule

// File: tb/tb_dma_fifo_drain.sv
// Bench for dma_fifo_drain: FIFO model, DMA responder with scripted wait states
// and error responses, and a word-level reference model of each transfer.
module tb_dma_fifo_drain;
  localparam int DATA = 16, ADDR_W = 15, LEN_W = 16, MAX_RETRY = 3;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic busy, done, error;
  logic [LEN_W-1:0] words_left;

  dma_fifo_drain_if #(.DATA(DATA), .ADDR_W(ADDR_W)) bus ();

  dma_fifo_drain #(.DATA(DATA), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .error(error),
    .words_left(words_left), .bus(bus)
  );

  always #5 clk = ~clk;

  // FIFO model: bench pushes at wp, DUT pops at rp.
  logic [DATA-1:0] fifo_mem [0:255];
  logic [7:0] fifo_wp = 8'd0, fifo_rp = 8'd0;
  assign bus.fifo_empty = (fifo_wp == fifo_rp);
  assign bus.fifo_out   = fifo_mem[fifo_rp];

  // DMA responder and monitors.
  int cyc = 0, grant_cnt = 0, pop_cnt = 0, done_cnt = 0, done_cyc = 0;
  int stab_err = 0, empty_pop = 0, we_err = 0;
  int ready_delay = 0, wait_cnt = 0, err_lo = 0, err_hi = 0;
  logic resp_r = 1'b0, prev_wait = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA-1:0]   prev_data = '0;
  logic [ADDR_W-1:0] log_addr [0:1023];
  logic [DATA-1:0]   log_data [0:1023];
  int                log_cyc  [0:1023];

  assign bus.dma_ready = bus.dma_en && (wait_cnt >= ready_delay);
  assign bus.dma_resp  = resp_r;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.fifo_enable) begin
      if (bus.fifo_empty) empty_pop <= empty_pop + 1;
      else fifo_rp <= fifo_rp + 8'd1;
      pop_cnt <= pop_cnt + 1;
    end
    if ((bus.dma_en && bus.dma_we != 2'b11) || (!bus.dma_en && bus.dma_we != 2'b00) ||
        bus.fifo_wr_rd != 1'b0)
      we_err <= we_err + 1;
    if (!rst) begin
      prev_wait <= 1'b0;
      resp_r    <= 1'b0;
      wait_cnt  <= 0;
    end else begin
      if (prev_wait && (!bus.dma_en || bus.dma_addr != prev_addr || bus.dma_din != prev_data))
        stab_err <= stab_err + 1;
      prev_wait <= bus.dma_en && !bus.dma_ready;
      prev_addr <= bus.dma_addr;
      prev_data <= bus.dma_din;
      if (bus.dma_en && bus.dma_ready) begin
        log_addr[grant_cnt % 1024] <= bus.dma_addr;
        log_data[grant_cnt % 1024] <= bus.dma_din;
        log_cyc[grant_cnt % 1024]  <= cyc;
        resp_r    <= (grant_cnt >= err_lo) && (grant_cnt < err_hi);
        grant_cnt <= grant_cnt + 1;
        wait_cnt  <= 0;
      end else begin
        resp_r   <= 1'b0;
        wait_cnt <= bus.dma_en ? wait_cnt + 1 : 0;
      end
    end
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DATA-1:0] v);
    fifo_mem[fifo_wp] = v;
    fifo_wp = fifo_wp + 8'd1;
  endtask

  task automatic flush();
    @(negedge clk);
    fifo_wp = fifo_rp;
  endtask

  // One transfer: len words from base, pre words in the FIFO before start and the
  // rest pushed at loop cycle feed_at, delay wait states per request, en error
  // responses starting at grant eskip, spurious start at cycle spur (0 = none).
  task automatic run_xfer(input string name, input logic [ADDR_W-1:0] b, input int len,
                          input int pre, input int feed_at, input int delay,
                          input int eskip, input int en, input int spur);
    logic [DATA-1:0]   w  [0:15];
    logic [ADDR_W-1:0] ea [0:63];
    logic [DATA-1:0]   ed [0:63];
    int g0, p0, d0, sc, timed_out, g, ok, fail, bad, got;
    for (int i = 0; i < len; i++) w[i] = DATA'($urandom);
    for (int i = 0; i < pre && i < len; i++) push(w[i]);
    ready_delay = delay;
    g0 = grant_cnt; p0 = pop_cnt; d0 = done_cnt;
    err_lo = g0 + eskip; err_hi = g0 + eskip + en;
    @(negedge clk);
    base_addr = b; length = LEN_W'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0; sc = cyc - 1;
    timed_out = 1;
    for (int k = 1; k <= 400; k++) begin
      if (spur > 0 && k == spur + 1) start = 1'b0;
      if (!busy) begin timed_out = 0; break; end
      if (k == feed_at) for (int i = pre; i < len; i++) push(w[i]);
      if (spur > 0 && k == spur) begin
        start = 1'b1; base_addr = ADDR_W'($urandom); length = LEN_W'($urandom_range(1, 9));
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    // Reference: each word is retried until accepted or MAX_RETRY+1 attempts fail.
    g = 0; ok = 0; fail = 0;
    for (int i = 0; i < len && fail == 0; i++) begin
      for (int a = 0; a <= MAX_RETRY; a++) begin
        bad = (g >= eskip && g < eskip + en) ? 1 : 0;
        ea[g] = ADDR_W'((int'(b) + i) % (1 << ADDR_W));
        ed[g] = w[i];
        g++;
        if (bad == 0) begin ok++; break; end
        if (a == MAX_RETRY) fail = 1;
      end
    end
    got = grant_cnt - g0;
    check({name, " timeout"}, timed_out, 0);
    check({name, " writes"}, got, g);
    for (int j = 0; j < g && j < got; j++) begin
      check($sformatf("%s addr[%0d]", name, j), log_addr[(g0 + j) % 1024], ea[j]);
      check($sformatf("%s data[%0d]", name, j), log_data[(g0 + j) % 1024], ed[j]);
    end
    check({name, " pops"}, pop_cnt - p0, ok + fail);
    check({name, " words_left"}, words_left, len - ok);
    check({name, " error"}, error, fail);
    check({name, " done_pulses"}, done_cnt - d0, (fail != 0) ? 0 : 1);
    check({name, " busy"}, busy, 0);
    if (fail == 0 && pre >= len)
      check({name, " done_cycle"}, done_cyc - sc, 1 + len + g * (2 + delay));
    if (got > 0 && pre >= 1)
      check({name, " first_dma_en"}, log_cyc[g0 % 1024] - sc, 2 + delay);
    $display("xfer %s base=%h len=%0d writes=%0d ok=%0d err=%0d", name, b, len, got, ok, fail);
    flush();
  endtask

  initial begin
    int g0, p0, d0, seen;
    logic [DATA-1:0] w0;
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
    check("rst words_left", words_left, 0);
    check("rst dma_addr", bus.dma_addr, 0);
    check("rst dma_din", bus.dma_din, 0);
    check("rst dma_en", bus.dma_en, 0);
    check("rst fifo_enable", bus.fifo_enable, 0);
    check("rst dma_we", bus.dma_we, 0);
    rst = 1'b1;
    @(negedge clk);

    run_xfer("basic", 15'h0100, 4, 4, 0, 0, 0, 0, 0);
    run_xfer("stall", 15'h0200, 2, 0, 5, 3, 0, 0, 0);
    run_xfer("retry", 15'h0300, 2, 2, 0, 1, 0, 2, 0);
    run_xfer("error", 15'h0400, 3, 3, 0, 0, 0, 4, 0);
    run_xfer("restart", 15'h0410, 3, 3, 0, 0, 0, 0, 0);
    run_xfer("wrap", 15'h7FFE, 3, 3, 0, 0, 0, 0, 0);
    push(16'hBEEF);
    run_xfer("zero", 15'h0500, 0, 0, 0, 0, 0, 0, 0);
    run_xfer("spurious", 15'h0600, 4, 4, 0, 1, 0, 0, 2);

    // Abort during WRITE: the held request completes, then done.
    w0 = 16'hA5C3;
    push(w0); push(16'h1111); push(16'h2222);
    ready_delay = 4; err_lo = 0; err_hi = 0;
    g0 = grant_cnt; p0 = pop_cnt; d0 = done_cnt;
    @(negedge clk); base_addr = 15'h0700; length = 16'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.dma_en) begin seen = 1; break; end
      @(negedge clk);
    end
    check("abort reached_write", seen, 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("abort writes", grant_cnt - g0, 1);
    check("abort addr", log_addr[g0 % 1024], 15'h0700);
    check("abort data", log_data[g0 % 1024], w0);
    check("abort pops", pop_cnt - p0, 1);
    check("abort words_left", words_left, 2);
    check("abort done_pulses", done_cnt - d0, 1);
    check("abort busy", busy, 0);
    $display("xfer abort base=0700 len=3 writes=%0d pops=%0d", grant_cnt - g0, pop_cnt - p0);
    flush();

    // Reset during WRITE.
    push(16'h3333); push(16'h4444); push(16'h5555);
    ready_delay = 3;
    d0 = done_cnt;
    @(negedge clk); base_addr = 15'h0800; length = 16'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.dma_en) begin seen = 1; break; end
      @(negedge clk);
    end
    check("mrst reached_write", seen, 1);
    rst = 1'b0;
    @(negedge clk);
    check("mrst dma_en", bus.dma_en, 0);
    check("mrst busy", busy, 0);
    check("mrst words_left", words_left, 0);
    check("mrst dma_addr", bus.dma_addr, 0);
    check("mrst dma_din", bus.dma_din, 0);
    check("mrst fifo_enable", bus.fifo_enable, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mrst no_done", done_cnt - d0, 0);
    $display("xfer midreset base=0800 len=3 busy=%0d", busy);
    flush();

    // Randomized transfers.
    for (int r = 0; r < 8; r++) begin
      int len;
      logic [ADDR_W-1:0] b;
      len = $urandom_range(1, 6);
      b = ($urandom_range(0, 1) == 1) ? ADDR_W'(15'h7FFC + $urandom_range(0, 3))
                                      : ADDR_W'($urandom);
      run_xfer($sformatf("rand%0d", r), b, len, len, 0, $urandom_range(0, 3),
               $urandom_range(0, len), $urandom_range(0, 4), 0);
    end

    check("global stable_wait", stab_err, 0);
    check("global pop_when_empty", empty_pop, 0);
    check("global we_decode", we_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
